// File: rtl/mul_pkg.sv
// Shared constants and FSM state encoding for the ARM7-style multiply/accumulate unit.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;
  localparam int NCHUNK        = DEFAULT_WIDTH / DEFAULT_CHUNK;
  localparam int CNT_W         = $clog2(NCHUNK + 1);

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_MUL  = 3'd1;
  localparam state_t S_LONG = 3'd2;
  localparam state_t S_ACC  = 3'd3;
  localparam state_t S_DONE = 3'd4;

endpackage

// File: rtl/mul_term_count.sv
// Early-termination iteration count: the fewest CHUNK-sized multiplier slices
// needed before the remaining upper bits of rs are all zeros (or all ones).
module mul_term_count
  import mul_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int CHUNK = DEFAULT_CHUNK,
  localparam int NCH   = WIDTH / CHUNK,
  localparam int CW    = $clog2(NCH + 1)
) (
  input  logic [WIDTH-1:0] rs,
  input  logic             sign_term,
  output logic [CW-1:0]    m
);

  // Scanning downward lets the smallest qualifying k win.
  always_comb begin
    m = CW'(NCH);
    for (int k = NCH - 1; k >= 1; k--) begin
      if (((rs >> (k * CHUNK)) == '0) ||
          (sign_term && ((~rs >> (k * CHUNK)) == '0))) begin
        m = CW'(k);
      end
    end
  end

endmodule

// File: rtl/mul_accumulate_unit.sv
// Iterative MUL/MLA/UMULL/SMULL/UMLAL/SMLAL unit with ARM7 early-termination
// timing, 2*WIDTH long results and a start/ready/done handshake.
module mul_accumulate_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic             op_long,
  input  logic             op_signed,
  input  logic             op_acc,
  input  logic [WIDTH-1:0] rm,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH + 1);
  localparam int W2  = 2 * WIDTH;

  state_t           state, state_next;
  logic [W2-1:0]    pp, pp_next, mcand, acc_val, chunk_prod, rm_ext;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt, m_count;
  logic             long_r, acc_en_r, neg_r;
  logic             accept, last_iter, sign_term;

  assign ready      = (state == S_IDLE) || (state == S_DONE);
  assign done       = (state == S_DONE);
  assign accept     = start && ready;
  assign sign_term  = !op_long || op_signed;
  assign rm_ext     = (op_long && op_signed) ? {{WIDTH{rm[WIDTH-1]}}, rm}
                                             : {{WIDTH{1'b0}}, rm};
  assign last_iter  = (cnt == CW'(1));
  assign chunk_prod = mcand * {{(W2-CHUNK){1'b0}}, mplier[CHUNK-1:0]};

  mul_term_count #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) u_term_count (
    .rs       (rs),
    .sign_term(sign_term),
    .m        (m_count)
  );

  // A multiplier that terminated on ones (or is negative at full width) was
  // consumed as rs_low; subtracting rm << (m*CHUNK) restores the true value.
  // Short ops fold that into the last iteration, long ops do it in LONG.
  always_comb begin
    state_next = state;
    pp_next    = pp;
    case (state)
      S_IDLE: if (start) state_next = S_MUL;
      S_MUL: begin
        pp_next = pp + chunk_prod;
        if (last_iter) begin
          if (neg_r && !long_r) pp_next = pp_next - (mcand << CHUNK);
          state_next = long_r ? S_LONG : (acc_en_r ? S_ACC : S_DONE);
        end
      end
      S_LONG: begin
        if (neg_r) pp_next = pp - mcand;
        state_next = acc_en_r ? S_ACC : S_DONE;
      end
      S_ACC: begin
        pp_next    = pp + acc_val;
        state_next = S_DONE;
      end
      S_DONE:  state_next = start ? S_MUL : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pp        <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      acc_val   <= '0;
      long_r    <= 1'b0;
      acc_en_r  <= 1'b0;
      neg_r     <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        pp       <= '0;
        mcand    <= rm_ext;
        mplier   <= rs;
        cnt      <= m_count;
        long_r   <= op_long;
        acc_en_r <= op_acc;
        neg_r    <= sign_term && rs[WIDTH-1];
        acc_val  <= op_acc ? {(op_long ? acc_hi : {WIDTH{1'b0}}), acc_lo} : '0;
      end else if (state == S_MUL) begin
        pp     <= pp_next;
        mcand  <= mcand << CHUNK;
        mplier <= mplier >> CHUNK;
        cnt    <= cnt - CW'(1);
      end else if ((state == S_LONG) || (state == S_ACC)) begin
        pp <= pp_next;
      end
      if (state_next == S_DONE) begin
        result_lo <= pp_next[WIDTH-1:0];
        result_hi <= long_r ? pp_next[W2-1:WIDTH] : '0;
        flag_n    <= long_r ? pp_next[W2-1] : pp_next[WIDTH-1];
        flag_z    <= long_r ? (pp_next == '0) : (pp_next[WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_mul_accumulate_unit.sv
// Scoreboard bench for mul_accumulate_unit: directed multiply-family vectors,
// busy/back-to-back handshake behaviour and mid-operation reset.
module tb_mul_accumulate_unit;

  logic        clk = 1'b0;
  logic        reset, start, ready, op_long, op_signed, op_acc, done;
  logic        flag_n, flag_z;
  logic [31:0] rm, rs, acc_lo, acc_hi, result_lo, result_hi;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  mul_accumulate_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ready    (ready),
    .op_long  (op_long),
    .op_signed(op_signed),
    .op_acc   (op_acc),
    .rm       (rm),
    .rs       (rs),
    .acc_lo   (acc_lo),
    .acc_hi   (acc_hi),
    .done     (done),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .flag_n   (flag_n),
    .flag_z   (flag_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the start is accepted on the next rising edge,
  // so done must appear at the falling edge where cyc == accept edge + lat.
  task automatic apply_stimulus(input string name, input logic lng, input logic sgn,
                                input logic acc, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] alo, input logic [31:0] ahi, input int lat,
                                input logic [31:0] elo, input logic [31:0] ehi,
                                input logic en, input logic ez, input bit push);
    int   n = 0;
    exp_t e;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_ready"}, {63'd0, ready}, 64'd1);
    op_long   = lng;
    op_signed = sgn;
    op_acc    = acc;
    rm        = a;
    rs        = b;
    acc_lo    = alo;
    acc_hi    = ahi;
    start     = 1'b1;
    if (push) begin
      e.name = name;
      e.lo   = elo;
      e.hi   = ehi;
      e.n    = en;
      e.z    = ez;
      e.at   = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every done pulse retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_output({e.name, "_lo"},    {32'd0, result_lo}, {32'd0, e.lo});
          check_output({e.name, "_hi"},    {32'd0, result_hi}, {32'd0, e.hi});
          check_output({e.name, "_n"},     {63'd0, flag_n},    {63'd0, e.n});
          check_output({e.name, "_z"},     {63'd0, flag_z},    {63'd0, e.z});
          check_output({e.name, "_cycle"}, 64'(cyc),           64'(e.at));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op_long = 1'b0; op_signed = 1'b0; op_acc = 1'b0;
    rm = '0; rs = '0; acc_lo = '0; acc_hi = '0;
    repeat (3) @(negedge clk);
    check_output("rst_ready", {63'd0, ready},     64'd1);
    check_output("rst_done",  {63'd0, done},      64'd0);
    check_output("rst_lo",    {32'd0, result_lo}, 64'd0);
    check_output("rst_hi",    {32'd0, result_hi}, 64'd0);
    check_output("rst_nz",    {62'd0, flag_n, flag_z}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    //             name          lng  sgn  acc  rm            rs            acc_lo        acc_hi        L  exp_lo        exp_hi        N     Z
    apply_stimulus("mul_3x5",    1'b0,1'b0,1'b0,32'd3,        32'd5,        32'd0,        32'd0,        1, 32'd15,       32'd0,        1'b0,1'b0,1'b1);
    apply_stimulus("mla_m3",     1'b0,1'b0,1'b1,32'd2,        32'h00012345, 32'd1,        32'd0,        4, 32'h0002468B, 32'd0,        1'b0,1'b0,1'b1);
    apply_stimulus("mul_neg_rs", 1'b0,1'b0,1'b0,32'd2,        32'hFFFFFF80, 32'd0,        32'd0,        1, 32'hFFFFFF00, 32'd0,        1'b1,1'b0,1'b1);
    apply_stimulus("umull_ones", 1'b1,1'b0,1'b0,32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        5, 32'h00000001, 32'hFFFFFFFE, 1'b1,1'b0,1'b1);
    apply_stimulus("smull_ones", 1'b1,1'b1,1'b0,32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        2, 32'h00000001, 32'd0,        1'b0,1'b0,1'b1);
    apply_stimulus("smlal_zero", 1'b1,1'b1,1'b1,32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,        3, 32'd0,        32'd0,        1'b0,1'b1,1'b1);
    apply_stimulus("umlal_cry",  1'b1,1'b0,1'b1,32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'd1,        5, 32'hFFFFFFFF, 32'd2,        1'b0,1'b0,1'b1);
    apply_stimulus("smull_mix",  1'b1,1'b1,1'b0,32'h7FFFFFFF, 32'h80000000, 32'd0,        32'd0,        5, 32'h80000000, 32'hC0000000, 1'b1,1'b0,1'b1);
    apply_stimulus("mla_sgnign", 1'b0,1'b1,1'b1,32'h80000000, 32'd2,        32'h80000000, 32'h0000DEAD, 2, 32'h80000000, 32'd0,        1'b1,1'b0,1'b1);
    apply_stimulus("mul_zero",   1'b0,1'b0,1'b0,32'h00001234, 32'd0,        32'd0,        32'd0,        1, 32'd0,        32'd0,        1'b0,1'b1,1'b1);

    // Busy-time start pulses with different operands must be ignored.
    apply_stimulus("umull_busy", 1'b1,1'b0,1'b0,32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        5, 32'h00000001, 32'hFFFFFFFE, 1'b1,1'b0,1'b1);
    repeat (2) begin
      op_long = 1'b0; rm = 32'd3; rs = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("busy_done_seen", {63'd0, done}, 64'd1);
    apply_stimulus("umull_b2b",  1'b1,1'b0,1'b0,32'd2,        32'hFFFFFFFF, 32'd0,        32'd0,        5, 32'hFFFFFFFE, 32'd1,        1'b0,1'b0,1'b1);

    // Abort: reset during the second cycle of an operation.
    apply_stimulus("umull_abort",1'b1,1'b0,1'b0,32'd5,        32'hFFFFFFFF, 32'd0,        32'd0,        5, 32'd0,        32'd0,        1'b0,1'b0,1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("abort_ready", {63'd0, ready},     64'd1);
    check_output("abort_done",  {63'd0, done},      64'd0);
    check_output("abort_lo",    {32'd0, result_lo}, 64'd0);
    check_output("abort_hi",    {32'd0, result_hi}, 64'd0);
    check_output("abort_nz",    {62'd0, flag_n, flag_z}, 64'd0);
    repeat (8) @(negedge clk);

    apply_stimulus("mul_after",  1'b0,1'b0,1'b0,32'd7,        32'd6,        32'd0,        32'd0,        1, 32'd42,       32'd0,        1'b0,1'b0,1'b1);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge clk);
    check_output("hold_lo", {32'd0, result_lo}, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_accumulate_unit.md
# mul_accumulate_unit

Parametrised iterative multiply/multiply-accumulate unit for the ALU. It executes the full ARM7TDMI multiply family: MUL, MLA, UMULL, SMULL, UMLAL and SMLAL. It reproduces the data-dependent early-termination cycle counts, and produces N/Z flags. It replaces the fixed 32-bit low-half-only multiplier with a start/ready/done handshake and 64-bit long results.

## Interface
- WIDTH, 32: operand width; must be a multiple of CHUNK.
- CHUNK, 8: multiplier bits retired per iteration cycle.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- ready  out  1  high in IDLE, including the cycle done is high.
- op_long  in  1  1 = 2·WIDTH result (xMULL/xMLAL).
- op_signed  in  1  long ops only: 1 = signed (SMULL/SMLAL), 0 = unsigned.
- op_acc  in  1  1 = accumulate (MLA/xMLAL).
- rm  in  WIDTH  multiplicand.
- rs  in  WIDTH  multiplier; its value sets the iteration count.
- acc_lo, acc_hi  in  WIDTH each  accumulator; acc_hi is used only when op_long=1.
- done  out  1  one-cycle pulse when the result is valid.
- result_lo, result_hi  out  WIDTH each  result; held until the next done.
- flag_n, flag_z  out  1 each  flags for the result; held with it.

## Operation
- All operands and op bits are captured on the accept edge. Later input changes have no effect.
- Non-long: result_lo = (rm·rs + (op_acc ? acc_lo : 0)) mod 2^WIDTH.
  - result_hi = 0.
  - flag_n = result_lo[WIDTH-1].
  - flag_z = (result_lo == 0).
  - op_signed is ignored.
- Long: {result_hi,result_lo} = (rm·rs + (op_acc ? {acc_hi,acc_lo} : 0)) mod 2^(2·WIDTH).
  - Operands are signed two's complement if op_signed=1, otherwise unsigned.
  - flag_n = result_hi[WIDTH-1].
  - flag_z = (all 2·WIDTH bits == 0).
- Iteration count m (1..WIDTH/CHUNK) is the smallest k such that rs[WIDTH-1:k·CHUNK] is "uniform", or WIDTH/CHUNK if none.
  - Uniform means all zeros, or all ones when sign-termination applies.
  - Sign-termination applies for non-long ops, and for long ops with op_signed=1.
  - Unsigned long ops accept all-zeros only.
- Result must be exact regardless of the early-termination path. When rs terminates on all ones, the implementation applies the negative correction.
- FSM states:
  - IDLE: ready=1. start goes to MUL.
  - MUL: one CHUNK per cycle for m cycles. Then go to LONG if op_long, else ACC if op_acc, else DONE.
  - LONG: 1 cycle of high-half formation. Then go to ACC if op_acc, else DONE.
  - ACC: 1 cycle of accumulator add. Then go to DONE.
  - DONE: done=1, ready=1, outputs updated. Returns to IDLE, or to MUL if start is asserted in this cycle.
- start while ready=0 is ignored and not queued.
- Reset values: state IDLE, ready=1, done=0, result_lo=result_hi=0, flag_n=flag_z=0.
- Reset mid-operation aborts it. No done is produced, and outputs take their reset values.

## Timing
- Latency L = m + op_long + op_acc cycles.
  - Start is accepted at edge t0.
  - done is high in the cycle following edge t0+L.
  - Gives MUL m, MLA m+1, xMULL m+1, xMLAL m+2 (ARM7 timing).
- ready falls in the cycle after acceptance and rises again in the DONE cycle.
- Back-to-back: a start in the DONE cycle is accepted, giving one result per L+1 cycles at most.
- result/flags change only on the edge entering DONE. They are stable from the done cycle until the next DONE.

## Structure
- Package mul_pkg holds:
  - the FSM state enum (IDLE, MUL, LONG, ACC, DONE);
  - default CHUNK/WIDTH constants;
  - localparam NCHUNK = WIDTH/CHUNK and the counter width $clog2(NCHUNK+1).
- Sub-module mul_term_count: combinational (rs, sign_term) → m. It is instantiated once and registered at accept.
- Datapath: a 2·WIDTH partial-product register, a shifting multiplier register and an iteration counter, all in the top module.

## Test plan
- MUL rm=3, rs=5 → L=1; result_lo=15, result_hi=0, N=0, Z=0.
- MLA rm=2, rs=0x00012345, acc_lo=1 → m=3, L=4; result_lo=0x0002468B.
- MUL rm=2, rs=0xFFFFFF80 → m=1, L=1; result_lo=0xFFFFFF00, N=1.
- UMULL vs SMULL, rm=rs=0xFFFFFFFF:
  - UMULL → L=5; hi=0xFFFFFFFE, lo=0x00000001.
  - SMULL → L=2; hi=0, lo=1.
- SMLAL rm=0xFFFFFFFF, rs=1, acc={0,1} → L=3; hi=lo=0, Z=1, N=0.
- Control-path checks, using UMULL rs=0xFFFFFFFF:
  - start pulses while busy → ignored.
  - start in the DONE cycle → second op accepted and done L+1 cycles later.
  - reset asserted in cycle 2 → no done; next cycle ready=1 and results=0.
